sequenciador_noite: RTL and testbench

SEQUENCIADOR_NOITE -- requirements
Module: sequenciador_noite

---
 rtl/sequenciador_noite.sv | 175 +++++++++++++++++
 tb/tb_sequenciador_noite.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_noite.sv
// sequenciador_noite: night-phase sequencer for the werewolf game.
// Walks the wolf, seer and doctor turns in order and skips any role that is absent.
// Each turn has a tick-based time limit. After the last turn it resolves the night's kill.
module sequenciador_noite #(
   parameter logic [4:0] TEMPO_TURNO = 5'd30
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       inicia,
   input  logic       confirma,
   input  logic       tick,
   input  logic [2:0] alvo,
   input  logic [7:0] vivos,
   input  logic       tem_vidente,
   input  logic       tem_medico,
   output logic [1:0] vez,
   output logic [4:0] tempo_restante,
   output logic [2:0] consulta,
   output logic       consulta_valida,
   output logic [2:0] morto,
   output logic       morte,
   output logic       fim_noite,
   output logic [3:0] db_estado
);

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      VEZ_LOBO    = 3'd1,
      VEZ_VIDENTE = 3'd2,
      VEZ_MEDICO  = 3'd3,
      RESOLVE     = 3'd4,
      FIM         = 3'd5
   } estado_t;

   estado_t    estado;
   estado_t    proximo;

   logic [2:0] vitima;
   logic       vitima_valida;
   logic [2:0] protegido;
   logic       protegido_valido;

   logic       em_vez;
   logic       proximo_em_vez;
   logic       entra_vez;
   logic       confirma_ok;
   logic       expira;
   logic       sai_vez;

   assign em_vez         = estado inside {VEZ_LOBO, VEZ_VIDENTE, VEZ_MEDICO};
   assign proximo_em_vez = proximo inside {VEZ_LOBO, VEZ_VIDENTE, VEZ_MEDICO};
   // A turn is entered on a state change into a turn state. This includes moving
   // from one turn straight to the next.
   assign entra_vez      = proximo_em_vez && (proximo != estado);
   // A confirmation counts only when the selected player is alive.
   assign confirma_ok    = em_vez && confirma && vivos[alvo];
   // The tick that takes the timer from 1 to 0 ends the turn.
   assign expira         = em_vez && tick && (tempo_restante == 5'd1);
   assign sai_vez        = confirma_ok || expira;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= proximo;
   end

   // Next-state selection, with the outputs decoded from the current state.
   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      proximo   = estado;
      vez       = 2'd0;
      fim_noite = 1'b0;
      db_estado = 4'hF;
      case (estado)
         OCIOSO: begin
            db_estado = 4'h0;
            if (inicia) proximo = VEZ_LOBO;
         end
         VEZ_LOBO: begin
            db_estado = 4'h1;
            vez       = 2'd1;
            if (sai_vez) begin
               if (tem_vidente)     proximo = VEZ_VIDENTE;
               else if (tem_medico) proximo = VEZ_MEDICO;
               else                 proximo = RESOLVE;
            end
         end
         VEZ_VIDENTE: begin
            db_estado = 4'h2;
            vez       = 2'd2;
            if (sai_vez) proximo = tem_medico ? VEZ_MEDICO : RESOLVE;
         end
         VEZ_MEDICO: begin
            db_estado = 4'h3;
            vez       = 2'd3;
            if (sai_vez) proximo = RESOLVE;
         end
         RESOLVE: begin
            db_estado = 4'h4;
            proximo   = FIM;
         end
         FIM: begin
            db_estado = 4'h5;
            fim_noite = 1'b1;
            proximo   = OCIOSO;
         end
         default: begin
            db_estado = 4'hF;
            proximo   = OCIOSO;
         end
      endcase
   end

   // Turn timer: reload on entering a turn, count ticks down inside a turn, and read 0 outside one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                  tempo_restante <= 5'd0;
      else if (entra_vez)                         tempo_restante <= TEMPO_TURNO;
      else if (!proximo_em_vez)                   tempo_restante <= 5'd0;
      else if (tick && (tempo_restante != 5'd0))  tempo_restante <= tempo_restante - 5'd1;
   end

   // Selection and outcome registers: cleared when a night starts, latched by valid confirmations, resolved once.
   // NOTE: reset clears every register, so an aborted night leaves no partial selection behind.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vitima           <= 3'd0;
         vitima_valida    <= 1'b0;
         protegido        <= 3'd0;
         protegido_valido <= 1'b0;
         consulta         <= 3'd0;
         consulta_valida  <= 1'b0;
         morto            <= 3'd0;
         morte            <= 1'b0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (inicia) begin
                  vitima           <= 3'd0;
                  vitima_valida    <= 1'b0;
                  protegido        <= 3'd0;
                  protegido_valido <= 1'b0;
                  consulta         <= 3'd0;
                  consulta_valida  <= 1'b0;
                  morte            <= 1'b0;
               end
            end
            VEZ_LOBO: begin
               if (confirma_ok) begin
                  vitima        <= alvo;
                  vitima_valida <= 1'b1;
               end
            end
            VEZ_VIDENTE: begin
               if (confirma_ok) begin
                  consulta        <= alvo;
                  consulta_valida <= 1'b1;
               end
            end
            VEZ_MEDICO: begin
               if (confirma_ok) begin
                  protegido        <= alvo;
                  protegido_valido <= 1'b1;
               end
            end
            RESOLVE: begin
               morte <= vitima_valida && !(protegido_valido && (protegido == vitima));
               morto <= vitima;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sequenciador_noite.sv
// tb_sequenciador_noite: self-checking bench for the night sequencer.
// It uses two instances, one with the default turn time and one with a 3-tick turn.
// A night-level model gives the expected turn order, timer values and outcome.
module tb_sequenciador_noite;

   logic       clock = 1'b0;
   logic       reset;
   logic       inicia;
   logic       confirma;
   logic       tick;
   logic [2:0] alvo;
   logic [7:0] vivos;
   logic       tem_vidente;
   logic       tem_medico;
   logic       sel;

   logic [1:0] vez_a, vez_b;
   logic [4:0] tempo_a, tempo_b;
   logic [2:0] consulta_a, consulta_b;
   logic       cv_a, cv_b;
   logic [2:0] morto_a, morto_b;
   logic       morte_a, morte_b;
   logic       fim_a, fim_b;
   logic [3:0] db_a, db_b;

   int checks   = 0;
   int failures = 0;

   // Turn plan for the next night (index 0 wolf, 1 seer, 2 doctor).
   int         plan_ticks[3];
   bit         plan_to[3];
   bit         plan_col[3];
   logic [2:0] plan_alvo[3];
   bit         ruido;

   always #5 clock = ~clock;

   sequenciador_noite dut_a (
      .clock(clock), .reset(reset), .inicia(inicia), .confirma(confirma), .tick(tick),
      .alvo(alvo), .vivos(vivos), .tem_vidente(tem_vidente), .tem_medico(tem_medico),
      .vez(vez_a), .tempo_restante(tempo_a), .consulta(consulta_a), .consulta_valida(cv_a),
      .morto(morto_a), .morte(morte_a), .fim_noite(fim_a), .db_estado(db_a)
   );

   sequenciador_noite #(.TEMPO_TURNO(5'd3)) dut_b (
      .clock(clock), .reset(reset), .inicia(inicia), .confirma(confirma), .tick(tick),
      .alvo(alvo), .vivos(vivos), .tem_vidente(tem_vidente), .tem_medico(tem_medico),
      .vez(vez_b), .tempo_restante(tempo_b), .consulta(consulta_b), .consulta_valida(cv_b),
      .morto(morto_b), .morte(morte_b), .fim_noite(fim_b), .db_estado(db_b)
   );

   wire [1:0] o_vez   = sel ? vez_b      : vez_a;
   wire [4:0] o_tempo = sel ? tempo_b    : tempo_a;
   wire [2:0] o_cons  = sel ? consulta_b : consulta_a;
   wire       o_cv    = sel ? cv_b       : cv_a;
   wire [2:0] o_morto = sel ? morto_b    : morto_a;
   wire       o_morte = sel ? morte_b    : morte_a;
   wire       o_fim   = sel ? fim_b      : fim_a;
   wire [3:0] o_db    = sel ? db_b       : db_a;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int turno();
      return sel ? 3 : 30;
   endfunction

   function automatic int jogador(input logic [7:0] v, input bit vivo);
      int i;
      do i = $urandom_range(0, 7); while (v[i] != vivo);
      return i;
   endfunction

   // One clock with the given inputs. Sampling happens 1 ns after the edge.
   task automatic ciclo(input logic i_ini, input logic i_conf, input logic i_tick, input logic [2:0] i_alvo);
      inicia   = i_ini;
      confirma = i_conf;
      tick     = i_tick;
      alvo     = i_alvo;
      @(posedge clock);
      #1;
      inicia   = 1'b0;
      confirma = 1'b0;
      tick     = 1'b0;
   endtask

   task automatic pulso_reset();
      #2 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic verifica_zeros(input string tag);
      check({tag, "_db"}, o_db, 0);
      check({tag, "_vez"}, o_vez, 0);
      check({tag, "_tempo"}, o_tempo, 0);
      check({tag, "_cons"}, o_cons, 0);
      check({tag, "_cv"}, o_cv, 0);
      check({tag, "_morto"}, o_morto, 0);
      check({tag, "_morte"}, o_morte, 0);
      check({tag, "_fim"}, o_fim, 0);
   endtask

   // Runs one whole night following the plan. The model keeps the turn list and the latched choices.
   task automatic noite(input logic [7:0] v, input logic tv, input logic tm);
      int         q[$];
      int         t;
      int         k;
      int         meta;
      int         r;
      bit         primeiro;
      bit         tem_morto;
      bit         dc;
      logic [2:0] vit, prot, cons;
      bit         vv, pv, cv;
      bit         exp_morte;
      vit = 0; prot = 0; cons = 0; vv = 0; pv = 0; cv = 0;
      vivos       = v;
      tem_vidente = tv;
      tem_medico  = tm;
      tem_morto   = (v != 8'hFF);
      t           = turno();
      q.push_back(1);
      if (tv) q.push_back(2);
      if (tm) q.push_back(3);
      ciclo(1'b1, 1'b0, 1'b0, 3'd0);
      for (int j = 0; j < q.size(); j++) begin
         r        = q[j];
         k        = 0;
         primeiro = 1'b1;
         check("vez_entrada", o_vez, r);
         check("tempo_entrada", o_tempo, t);
         meta = plan_to[r-1] ? t : plan_ticks[r-1];
         while (k < meta || (ruido && primeiro)) begin
            if (ruido && (primeiro || $urandom_range(0, 2) == 0)) begin
               // Cycle with no tick: a stray inicia and/or a confirma on a dead player; neither may have an effect.
               dc = tem_morto && ($urandom_range(0, 1) == 1 || primeiro);
               ciclo($urandom_range(0, 1) == 1, dc, 1'b0, dc ? 3'(jogador(v, 1'b0)) : 3'd0);
               check("vez_ruido", o_vez, r);
               check("tempo_ruido", o_tempo, t - k);
               primeiro = 1'b0;
               if (k >= meta) break;
            end
            dc = ruido && tem_morto && ($urandom_range(0, 2) == 0);
            ciclo(1'b0, dc, 1'b1, dc ? 3'(jogador(v, 1'b0)) : 3'd0);
            k++;
            if (k < t) begin
               check("vez_tick", o_vez, r);
               check("tempo_tick", o_tempo, t - k);
            end
         end
         if (!plan_to[r-1]) begin
            ciclo(1'b0, 1'b1, plan_col[r-1], plan_alvo[r-1]);
            case (r)
               1: begin vit  = plan_alvo[0]; vv = 1'b1; end
               2: begin cons = plan_alvo[1]; cv = 1'b1; end
               default: begin prot = plan_alvo[2]; pv = 1'b1; end
            endcase
         end
      end
      check("resolve_db", o_db, 4);
      check("resolve_vez", o_vez, 0);
      check("resolve_tempo", o_tempo, 0);
      check("resolve_fim", o_fim, 0);
      ciclo(1'b0, 1'b0, 1'b0, 3'd0);
      exp_morte = vv && !(pv && prot == vit);
      check("fim_db", o_db, 5);
      check("fim_pulso", o_fim, 1);
      check("fim_tempo", o_tempo, 0);
      check("fim_morte", o_morte, int'(exp_morte));
      check("fim_morto", o_morto, vit);
      check("fim_cons", o_cons, cons);
      check("fim_cv", o_cv, int'(cv));
      for (int n = 0; n < 2; n++) begin
         ciclo(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
         check("ocioso_db", o_db, 0);
         check("ocioso_fim", o_fim, 0);
         check("ocioso_tempo", o_tempo, 0);
         check("ocioso_morte", o_morte, int'(exp_morte));
         check("ocioso_morto", o_morto, vit);
         check("ocioso_cons", o_cons, cons);
         check("ocioso_cv", o_cv, int'(cv));
      end
   endtask

   task automatic plano(input int tk0, input int tk1, input int tk2,
                        input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
      plan_ticks[0] = tk0; plan_ticks[1] = tk1; plan_ticks[2] = tk2;
      plan_alvo[0]  = a0;  plan_alvo[1]  = a1;  plan_alvo[2]  = a2;
      for (int i = 0; i < 3; i++) begin
         plan_to[i]  = 1'b0;
         plan_col[i] = 1'b0;
      end
      ruido = 1'b0;
   endtask

   initial begin
      logic [7:0] v;
      bit         novo_sel;
      sel = 1'b0; reset = 1'b1;
      inicia = 0; confirma = 0; tick = 0; alvo = 0;
      vivos = 8'hFF; tem_vidente = 1; tem_medico = 1;
      #2;
      verifica_zeros("reset_ini");
      @(posedge clock);
      #1 reset = 1'b0;

      // Full night: wolf picks 3, seer queries 5, doctor protects 2.
      plano(0, 0, 0, 3'd3, 3'd5, 3'd2);
      noite(8'hFF, 1'b1, 1'b1);
      // Doctor saves the victim.
      plano(2, 1, 0, 3'd3, 3'd5, 3'd3);
      noite(8'hFF, 1'b1, 1'b1);
      // Dead target is ignored, and both roles are skipped.
      plano(0, 0, 0, 3'd1, 3'd0, 3'd0);
      ruido = 1'b1;
      noite(8'hF7, 1'b0, 1'b0);
      // Confirma and the last tick arrive in the same cycle.
      plano(29, 0, 0, 3'd4, 3'd0, 3'd1);
      plan_col[0] = 1'b1;
      noite(8'hFF, 1'b1, 1'b1);

      // Mid-night reset in the seer turn: everything clears at once, and no pulse follows.
      vivos = 8'hFF; tem_vidente = 1; tem_medico = 1;
      ciclo(1'b1, 1'b0, 1'b0, 3'd0);
      ciclo(1'b0, 1'b1, 1'b0, 3'd6);
      check("pre_reset_vez", o_vez, 2);
      #2 reset = 1'b1;
      #1;
      verifica_zeros("reset_meio");
      @(posedge clock);
      #1 reset = 1'b0;
      for (int n = 0; n < 6; n++) begin
         ciclo(1'b0, 1'b0, 1'b1, 3'd0);
         check("pos_reset_fim", o_fim, 0);
         check("pos_reset_db", o_db, 0);
      end
      // After the reset, a clean night has every turn time out.
      plano(0, 0, 0, 3'd0, 3'd0, 3'd0);
      for (int i = 0; i < 3; i++) plan_to[i] = 1'b1;
      noite(8'hFF, 1'b1, 1'b1);

      // Timeout on the 3-tick instance.
      sel = 1'b1;
      pulso_reset();
      plano(0, 0, 0, 3'd0, 3'd0, 3'd0);
      for (int i = 0; i < 3; i++) plan_to[i] = 1'b1;
      noite(8'hFF, 1'b1, 1'b1);

      // Randomised nights on both instances.
      for (int n = 0; n < 40; n++) begin
         novo_sel = ($urandom_range(0, 1) == 1);
         if (novo_sel != sel) begin
            sel = novo_sel;
            pulso_reset();
         end
         v = 8'($urandom);
         if (v == 8'h00) v = 8'h01;
         for (int i = 0; i < 3; i++) begin
            plan_to[i]    = ($urandom_range(0, 3) == 0);
            plan_ticks[i] = $urandom_range(0, turno() - 1);
            plan_col[i]   = ($urandom_range(0, 1) == 1);
            plan_alvo[i]  = 3'(jogador(v, 1'b1));
         end
         ruido = ($urandom_range(0, 1) == 1);
         noite(v, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
